imul_iter_4b: RTL and testbench

//   Iterative shift-and-add unsigned multiplier for the TinyRV1 datapath.

---
 rtl/imul_iter_4b.sv | 101 ++++++++++
 tb/tb_imul_iter_4b.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imul_iter_4b.sv
// Iterative shift-and-add unsigned multiplier with val/rdy operand and product streams.
// One product per NBITS+2 cycles; prod mirrors the accumulator at all times.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for operands; prod holds the last product
//   CALC  | NBITS shift/add steps, one per cycle, no early exit
//   DONE  | product valid; holds until the consumer takes it
module imul_iter_4b #(
  parameter int NBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] prod
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [2*NBITS-1:0]   a;
  logic [NBITS-1:0]     b;
  logic [2*NBITS-1:0]   res;
  logic [CNT_W-1:0]     cnt;
  logic                 last_step;

  assign last_step = (cnt == CNT_W'(NBITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Handshake outputs depend on state only, never on the incoming val/rdy.
  always_comb begin
    state_nx    = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) state_nx = CALC;
      end
      CALC: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Each register picks between its load value (accept) and its shifted value (CALC).
  always_ff @(posedge clk) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      res <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a   <= {{NBITS{1'b0}}, in0};
            b   <= in1;
            res <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          if (b[0]) res <= res + a;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign prod = res;

endmodule

// File: tb/tb_imul_iter_4b.sv
// Scoreboard bench for imul_iter_4b: stimulus pushes expected products, a
// negedge monitor pops and compares on every output handshake.
module tb_imul_iter_4b;

  localparam int NBITS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       istream_val = 1'b0;
  logic       istream_rdy;
  logic [3:0] in0 = '0;
  logic [3:0] in1 = '0;
  logic       ostream_val;
  logic       ostream_rdy = 1'b0;
  logic [7:0] prod;

  imul_iter_4b #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .in0         (in0),
    .in1         (in1),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .prod        (prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of ostream_val, value on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (ostream_val && !prev_val) begin
        if (exp_q.size() == 0) chk("unexpected_val", 1, 0);
        else chk("latency", cyc - exp_q[0].acc, NBITS);
      end
      if (ostream_val && ostream_rdy && exp_q.size() > 0) begin
        chk("prod", int'(prod), int'(exp_q[0].p));
        void'(exp_q.pop_front());
      end
    end
    prev_val = ostream_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!istream_rdy && t < 20) begin
      step();
      t++;
    end
    if (!istream_rdy) chk("istream_rdy_timeout", 0, 1);
  endtask

  task automatic wait_oval();
    int t = 0;
    while (!ostream_val && t < 20) begin
      step();
      t++;
    end
    if (!ostream_val) chk("ostream_val_timeout", 0, 1);
  endtask

  task automatic issue(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    wait_rdy();
    istream_val = 1'b1;
    in0 = x;
    in1 = y;
    e.p   = 8'(x) * 8'(y);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    step();
    istream_val = 1'b0;
    in0 = ~x;
    in1 = ~y;
  endtask

  task automatic run_txn(input logic [3:0] x, input logic [3:0] y, input int stall);
    ostream_rdy = (stall == 0);
    issue(x, y);
    wait_oval();
    repeat (stall) step();
    ostream_rdy = 1'b1;
    step();
    ostream_rdy = 1'b0;
    chk("idle_after_done", int'(istream_rdy), 1);
    chk("val_low_after_done", int'(ostream_val), 0);
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_istream_rdy", int'(istream_rdy), 1);
    chk("reset_ostream_val", int'(ostream_val), 0);
    chk("reset_prod", int'(prod), 0);

    run_txn(4'd3, 4'd5, 0);
    chk("prod_held_in_idle", int'(prod), 15);

    run_txn(4'd15, 4'd15, 0);
    run_txn(4'd0, 4'd9, 0);
    run_txn(4'd9, 4'd0, 0);
    run_txn(4'd1, 4'd15, 0);

    // Backpressure: DONE holds while new operands are offered and ignored.
    ostream_rdy = 1'b0;
    issue(4'd6, 4'd7);
    wait_oval();
    istream_val = 1'b1;
    in0 = 4'd9;
    in1 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ostream_val", int'(ostream_val), 1);
      chk("bp_prod", int'(prod), 42);
      chk("bp_istream_rdy", int'(istream_rdy), 0);
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    step();
    ostream_rdy = 1'b0;
    chk("bp_idle_after", int'(istream_rdy), 1);
    chk("bp_prod_kept", int'(prod), 42);

    // Reset in the second CALC cycle drops the transaction.
    wait_rdy();
    istream_val = 1'b1;
    in0 = 4'd13;
    in1 = 4'd11;
    step();
    istream_val = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_istream_rdy", int'(istream_rdy), 1);
    chk("midreset_ostream_val", int'(ostream_val), 0);
    chk("midreset_prod", int'(prod), 0);
    ostream_rdy = 1'b1;
    repeat (8) step();
    chk("midreset_no_val", int'(ostream_val), 0);
    run_txn(4'd2, 4'd3, 0);

    for (int i = 0; i < 15; i++) begin
      run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
